// File: rtl/stage_id_pipe_pkg.sv
// Shared decode constants and bundles for the ID stage.
// Opcodes, functs, ALU op/select encodings and the decode bundle.
package stage_id_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;

  localparam logic [7:0] ALUOP_NOP = 8'b00000000;
  localparam logic [7:0] ALUOP_AND = 8'b00100100;
  localparam logic [7:0] ALUOP_OR  = 8'b00100101;
  localparam logic [7:0] ALUOP_XOR = 8'b00100110;
  localparam logic [7:0] ALUOP_NOR = 8'b00100111;
  localparam logic [7:0] ALUOP_SLL = 8'b01111100;
  localparam logic [7:0] ALUOP_SRL = 8'b00000010;
  localparam logic [7:0] ALUOP_SRA = 8'b00000011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  typedef struct packed {
    logic       re1;
    logic       re2;
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic       we;
    logic [4:0] waddr;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/stage_id_pipe_id_decode.sv
// Pure combinational instruction decoder for the ID stage.
// Produces control bundle plus the two immediate operand candidates.
module id_decode
  import stage_id_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output dec_t            dec,
  output logic [XLEN-1:0] imm1,
  output logic [XLEN-1:0] imm2
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       is_logic_r;
  logic       is_shift;
  logic       is_logic_i;

  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign rt = inst[20:16];
  assign rd = inst[15:11];

  assign is_logic_r = (op == OP_SPECIAL) && (fn[5:2] == 4'b1001);
  assign is_shift   = (op == OP_SPECIAL) &&
                      ((fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA));
  assign is_logic_i = (op[5:2] == 4'b0011);

  always_comb begin
    dec  = '0;
    imm1 = '0;
    imm2 = '0;
    unique case (1'b1)
      is_logic_r: begin
        dec.re1    = 1'b1;
        dec.re2    = 1'b1;
        dec.aluop  = {2'b00, fn};
        dec.alusel = SEL_LOGIC;
        dec.we     = 1'b1;
        dec.waddr  = rd;
      end
      is_shift: begin
        dec.re2    = 1'b1;
        dec.alusel = SEL_SHIFT;
        dec.waddr  = rd;
        imm1       = XLEN'(inst[10:6]);
        // sll $0 is the canonical nop
        dec.we     = !((fn == F_SLL) && (rd == 5'd0));
        unique case (1'b1)
          fn == F_SLL: dec.aluop = ALUOP_SLL;
          fn == F_SRL: dec.aluop = ALUOP_SRL;
          default:     dec.aluop = ALUOP_SRA;
        endcase
      end
      is_logic_i: begin
        dec.alusel = SEL_LOGIC;
        dec.we     = 1'b1;
        dec.waddr  = rt;
        dec.re1    = (op != OP_LUI);
        imm2       = (op == OP_LUI) ? XLEN'({inst[15:0], 16'h0000})
                                    : XLEN'(inst[15:0]);
        unique case (1'b1)
          op == OP_ANDI: dec.aluop = ALUOP_AND;
          op == OP_XORI: dec.aluop = ALUOP_XOR;
          default:       dec.aluop = ALUOP_OR;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/stage_id_pipe.sv
// Decode stage with forwarding, load-use stall and ID/EX register.
// Valid/ready handshake on both the IF/ID and EX sides.
module stage_id_pipe
  import stage_id_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int RAW  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      pc,
  input  logic [31:0]          inst,
  output logic                 re1,
  output logic                 re2,
  output logic [RAW-1:0]       raddr1,
  output logic [RAW-1:0]       raddr2,
  input  logic [XLEN-1:0]      rdata1,
  input  logic [XLEN-1:0]      rdata2,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD-1:0]      fwd_pend,
  input  logic [NFWD*RAW-1:0]  fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [7:0]           aluop,
  output logic [2:0]           alusel,
  output logic [XLEN-1:0]      opv1,
  output logic [XLEN-1:0]      opv2,
  output logic                 we,
  output logic [RAW-1:0]       waddr,
  output logic                 illegal
);

  dec_t            dec;
  logic [XLEN-1:0] imm1;
  logic [XLEN-1:0] imm2;

  id_decode #(.XLEN(XLEN)) u_dec (
    .inst (inst),
    .dec  (dec),
    .imm1 (imm1),
    .imm2 (imm2)
  );

  assign re1    = dec.re1;
  assign re2    = dec.re2;
  assign raddr1 = RAW'(inst[25:21]);
  assign raddr2 = RAW'(inst[20:16]);

  logic [NFWD-1:0] hit1;
  logic [NFWD-1:0] hit2;
  logic [XLEN-1:0] wdata [NFWD];

  for (genvar i = 0; i < NFWD; i++) begin : g_fwd
    assign wdata[i] = fwd_wdata[i*XLEN +: XLEN];
    assign hit1[i]  = fwd_we[i] && (fwd_waddr[i*RAW +: RAW] == raddr1);
    assign hit2[i]  = fwd_we[i] && (fwd_waddr[i*RAW +: RAW] == raddr2);
  end

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            pend1;
  logic            pend2;

  // Walk oldest to youngest so the lowest index wins
  always_comb begin
    op1   = rdata1;
    op2   = rdata2;
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (hit1[i]) begin
        op1   = wdata[i];
        pend1 = fwd_pend[i];
      end
      if (hit2[i]) begin
        op2   = wdata[i];
        pend2 = fwd_pend[i];
      end
    end
    if (raddr1 == '0) begin
      op1   = '0;
      pend1 = 1'b0;
    end
    if (raddr2 == '0) begin
      op2   = '0;
      pend2 = 1'b0;
    end
    if (!dec.re1) begin
      op1   = imm1;
      pend1 = 1'b0;
    end
    if (!dec.re2) begin
      op2   = imm2;
      pend2 = 1'b0;
    end
  end

  logic stall;
  logic adv;
  logic load;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q,    out_pc_d;
  logic [7:0]      aluop_q,     aluop_d;
  logic [2:0]      alusel_q,    alusel_d;
  logic [XLEN-1:0] opv1_q,      opv1_d;
  logic [XLEN-1:0] opv2_q,      opv2_d;
  logic            we_q,        we_d;
  logic [RAW-1:0]  waddr_q,     waddr_d;
  logic            illegal_q,   illegal_d;

  assign stall    = in_valid && (pend1 || pend2);
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !stall && !flush;
  assign load     = in_valid && !stall;

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    aluop_d     = aluop_q;
    alusel_d    = alusel_q;
    opv1_d      = opv1_q;
    opv2_d      = opv2_q;
    we_d        = we_q;
    waddr_d     = waddr_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_pc_d    = '0;
      aluop_d     = '0;
      alusel_d    = '0;
      opv1_d      = '0;
      opv2_d      = '0;
      we_d        = 1'b0;
      waddr_d     = '0;
      illegal_d   = 1'b0;
    end else if (adv) begin
      out_valid_d = load;
      out_pc_d    = load ? pc          : '0;
      aluop_d     = load ? dec.aluop   : '0;
      alusel_d    = load ? dec.alusel  : '0;
      opv1_d      = load ? op1         : '0;
      opv2_d      = load ? op2         : '0;
      we_d        = load && dec.we;
      waddr_d     = load ? RAW'(dec.waddr) : '0;
      illegal_d   = load && dec.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      aluop_q     <= '0;
      alusel_q    <= '0;
      opv1_q      <= '0;
      opv2_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      aluop_q     <= aluop_d;
      alusel_q    <= alusel_d;
      opv1_q      <= opv1_d;
      opv2_q      <= opv2_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign aluop     = aluop_q;
  assign alusel    = alusel_q;
  assign opv1      = opv1_q;
  assign opv2      = opv2_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed scoreboard bench for stage_id_pipe.
// Register file returns 0x5A00_0000 | addr on each read port.
module tb_stage_id_pipe;

  localparam int XLEN = 32;
  localparam int NFWD = 2;
  localparam int RAW  = 5;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready;
  logic [31:0]     pc, inst;
  logic            re1, re2;
  logic [4:0]      raddr1, raddr2;
  logic [31:0]     rdata1, rdata2;
  logic [1:0]      fwd_we, fwd_pend;
  logic [9:0]      fwd_waddr;
  logic [63:0]     fwd_wdata;
  logic            out_valid, out_ready;
  logic [31:0]     out_pc, opv1, opv2;
  logic [7:0]      aluop;
  logic [2:0]      alusel;
  logic            we, illegal;
  logic [4:0]      waddr;

  always #5 clk = ~clk;

  stage_id_pipe #(.XLEN(XLEN), .NFWD(NFWD), .RAW(RAW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .inst(inst),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .fwd_we(fwd_we), .fwd_pend(fwd_pend),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .aluop(aluop), .alusel(alusel), .opv1(opv1), .opv2(opv2),
    .we(we), .waddr(waddr), .illegal(illegal)
  );

  function automatic logic [31:0] rf(input logic [4:0] r);
    return 32'h5A00_0000 | {27'b0, r};
  endfunction

  always_comb rdata1 = rf(raddr1);
  always_comb rdata2 = rf(raddr2);

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] o1;
    logic [31:0] o2;
    logic        we;
    logic [4:0]  wa;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic exp_t mk(input logic [31:0] p, input logic [7:0] op,
                              input logic [2:0] sel, input logic [31:0] a,
                              input logic [31:0] b, input logic w,
                              input logic [4:0] wa, input logic il);
    exp_t e;
    e.pc = p; e.aluop = op; e.alusel = sel; e.o1 = a; e.o2 = b;
    e.we = w; e.wa = wa; e.ill = il;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"},   32'(out_valid), 32'd1);
      chk({tag, ".pc"},      out_pc,         e.pc);
      chk({tag, ".aluop"},   32'(aluop),     32'(e.aluop));
      chk({tag, ".alusel"},  32'(alusel),    32'(e.alusel));
      chk({tag, ".opv1"},    opv1,           e.o1);
      chk({tag, ".opv2"},    opv2,           e.o2);
      chk({tag, ".we"},      32'(we),        32'(e.we));
      chk({tag, ".waddr"},   32'(waddr),     32'(e.wa));
      chk({tag, ".illegal"}, 32'(illegal),   32'(e.ill));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] i);
    pc = p;
    inst = i;
    in_valid = 1'b1;
  endtask

  task automatic setfwd(input int i, input logic w, input logic pd,
                        input logic [4:0] a, input logic [31:0] d);
    fwd_we[i] = w;
    fwd_pend[i] = pd;
    fwd_waddr[i*5 +: 5] = a;
    fwd_wdata[i*32 +: 32] = d;
  endtask

  task automatic clrfwd();
    fwd_we = '0;
    fwd_pend = '0;
    fwd_waddr = '0;
    fwd_wdata = '0;
  endtask

  localparam logic [31:0] I_ORI  = 32'h3401_1100;
  localparam logic [31:0] I_OR   = 32'h0022_1825;
  localparam logic [31:0] I_OR0  = 32'h0002_1825;
  localparam logic [31:0] I_AND  = 32'h0022_1824;
  localparam logic [31:0] I_LUI  = 32'h3C05_ABCD;
  localparam logic [31:0] I_SRA  = 32'h0004_10C3;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    pc = '0;
    inst = '0;
    out_ready = 1'b1;
    clrfwd();
    tick();
    tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.pc",    out_pc,         32'd0);
    chk("rst.aluop", 32'(aluop),     32'd0);
    chk("rst.opv2",  opv2,           32'd0);
    chk("rst.we",    32'(we),        32'd0);
    rst_n = 1'b1;

    drive(32'h100, I_ORI);
    #4;
    chk("t1.in_ready", 32'(in_ready), 32'd1);
    chk("t1.re2",      32'(re2),      32'd0);
    sb.push_back(mk(32'h100, 8'h25, 3'd1, 32'd0, 32'h1100, 1'b1, 5'd1, 1'b0));
    tick();
    pop_check("t1");

    setfwd(0, 1'b1, 1'b0, 5'd1, 32'hA);
    setfwd(1, 1'b1, 1'b0, 5'd1, 32'hB);
    drive(32'h104, I_OR);
    #4;
    chk("t2.raddr1", 32'(raddr1), 32'd1);
    chk("t2.raddr2", 32'(raddr2), 32'd2);
    sb.push_back(mk(32'h104, 8'h25, 3'd1, 32'hA, rf(5'd2), 1'b1, 5'd3, 1'b0));
    tick();
    pop_check("t2.fwd0");

    setfwd(0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(32'h108, I_OR);
    sb.push_back(mk(32'h108, 8'h25, 3'd1, 32'hB, rf(5'd2), 1'b1, 5'd3, 1'b0));
    tick();
    pop_check("t2.fwd1");

    clrfwd();
    setfwd(0, 1'b1, 1'b0, 5'd0, 32'hDEAD);
    setfwd(1, 1'b1, 1'b0, 5'd2, 32'hC2);
    drive(32'h10C, I_OR0);
    sb.push_back(mk(32'h10C, 8'h25, 3'd1, 32'd0, 32'hC2, 1'b1, 5'd3, 1'b0));
    tick();
    pop_check("t2.zero");

    clrfwd();
    setfwd(0, 1'b1, 1'b1, 5'd1, 32'h55);
    drive(32'h110, I_AND);
    #4;
    chk("t3.stall_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t3.bubble_valid", 32'(out_valid), 32'd0);
    chk("t3.bubble_we",    32'(we),        32'd0);
    setfwd(0, 1'b1, 1'b0, 5'd1, 32'h77);
    #4;
    chk("t3.release_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(32'h110, 8'h24, 3'd1, 32'h77, rf(5'd2), 1'b1, 5'd3, 1'b0));
    tick();
    pop_check("t3.issue");

    setfwd(0, 1'b1, 1'b0, 5'd1, 32'h11);
    setfwd(1, 1'b1, 1'b1, 5'd1, 32'h22);
    drive(32'h114, I_AND);
    #4;
    chk("t3.shadow_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(32'h114, 8'h24, 3'd1, 32'h11, rf(5'd2), 1'b1, 5'd3, 1'b0));
    tick();
    pop_check("t3.shadow");

    clrfwd();
    in_valid = 1'b0;
    tick();
    chk("t4.idle_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(32'h118, I_ORI);
    #4;
    chk("t4.accept_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(32'h118, 8'h25, 3'd1, 32'd0, 32'h1100, 1'b1, 5'd1, 1'b0));
    tick();
    pop_check("t4.a");
    drive(32'h11C, I_LUI);
    for (int k = 0; k < 3; k++) begin
      #4;
      chk("t4.hold_ready", 32'(in_ready), 32'd0);
      tick();
      chk("t4.hold_valid", 32'(out_valid), 32'd1);
      chk("t4.hold_pc",    out_pc,         32'h118);
      chk("t4.hold_opv2",  opv2,           32'h1100);
    end
    out_ready = 1'b1;
    #4;
    chk("t4.release_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(32'h11C, 8'h25, 3'd1, 32'd0, 32'hABCD_0000, 1'b1, 5'd5, 1'b0));
    tick();
    pop_check("t6.lui");

    flush = 1'b1;
    drive(32'h120, I_SRA);
    #4;
    chk("t5.flush_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t5.flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    #4;
    chk("t5.after_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(32'h120, 8'h03, 3'd2, 32'd3, rf(5'd4), 1'b1, 5'd2, 1'b0));
    tick();
    pop_check("t6.sra");

    out_ready = 1'b0;
    setfwd(0, 1'b1, 1'b1, 5'd1, 32'h33);
    drive(32'h124, I_AND);
    #4;
    chk("t5.stall_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("t5.rst_valid", 32'(out_valid), 32'd0);
    chk("t5.rst_pc",    out_pc,         32'd0);
    chk("t5.rst_aluop", 32'(aluop),     32'd0);
    chk("t5.rst_opv1",  opv1,           32'd0);
    chk("t5.rst_waddr", 32'(waddr),     32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    clrfwd();

    drive(32'h128, I_ILL);
    #4;
    chk("t6.ill_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(32'h128, 8'h00, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1));
    tick();
    pop_check("t6.illegal");
    drive(32'h12C, I_NOP);
    sb.push_back(mk(32'h12C, 8'h7C, 3'd2, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0));
    tick();
    pop_check("t6.nop");
    in_valid = 1'b0;
    tick();
    chk("end.valid", 32'(out_valid), 32'd0);
    chk("end.sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
